tug_score_keeper: RTL and testbench

- Downstream of the nine-light tug-of-war playfield.
- Watches the two edge lights and the conditioned player press pulses L and R, and decides when a round is won.
- Keeps per-player scores, drives two active-low seven-segment digits, and issues a round_reset that re-centres the playfield.
- Latches the match winner when a player reaches MAX_SCORE.

---
 rtl/tug_score_keeper.sv | 158 +++++++++++++++
 tb/tb_tug_score_keeper.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tug_score_keeper.sv
// tug_score_keeper
//   Scorekeeper for the nine-light tug-of-war playfield. It decides when a round is won, keeps the
//   per-player scores and shows them on two seven-segment digits. After each round win it holds
//   round_reset high so the playfield re-centres. When a player reaches MAX_SCORE it latches the
//   match winner.
//
// Parameters
//   MAX_SCORE   : round wins that end the match (1..9)
//   HOLD_CYCLES : cycles round_reset stays high after a non-final round win (1..255)
//
// Ports
//   clk         : system clock, rising-edge
//   reset       : synchronous active-low reset
//   L, R        : single-cycle, already-conditioned player press pulses
//   led_left    : leftmost playfield light
//   led_right   : rightmost playfield light
//   HEX1, HEX0  : left / right score digits, active-low {g,f,e,d,c,b,a}
//   round_reset : forces the playfield back to its centre light
//   game_over   : high once the match is decided
//   winner      : 2'b10 left, 2'b01 right, 2'b00 none
module tug_score_keeper #(
   parameter int unsigned MAX_SCORE   = 7,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       L,
   input  logic       R,
   input  logic       led_left,
   input  logic       led_right,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0,
   output logic       round_reset,
   output logic       game_over,
   output logic [1:0] winner
);

   typedef enum logic [1:0] {
      StPlay,
      StHold,
      StOver
   } state_e;

   localparam logic [3:0] MaxScoreC  = 4'(MAX_SCORE);
   localparam logic [7:0] HoldInitC  = 8'(HOLD_CYCLES - 1);
   localparam logic [6:0] SegZeroC   = 7'b1000000;

   state_e     state_q, state_d;
   logic [3:0] score_l_q, score_l_d;
   logic [3:0] score_r_q, score_r_d;
   logic [7:0] hold_q, hold_d;
   logic       round_reset_q, round_reset_d;
   logic       game_over_q, game_over_d;
   logic [1:0] winner_q, winner_d;

   logic       left_win, right_win;
   logic [3:0] new_score;

   // Active-low seven-segment decode; out-of-range values blank the digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SegZeroC;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // A simultaneous press is a tie: the playfield does not move, so nobody scores.
   assign left_win  = L & ~R & led_left;
   assign right_win = R & ~L & led_right;

   always_comb begin
      state_d       = state_q;
      score_l_d     = score_l_q;
      score_r_d     = score_r_q;
      hold_d        = hold_q;
      round_reset_d = round_reset_q;
      game_over_d   = game_over_q;
      winner_d      = winner_q;
      new_score     = left_win ? (score_l_q + 4'd1) : (score_r_q + 4'd1);

      case (state_q)
         StPlay: begin
            round_reset_d = 1'b0;
            if (left_win || right_win) begin
               if (left_win) begin
                  score_l_d = new_score;
               end else begin
                  score_r_d = new_score;
               end
               round_reset_d = 1'b1;
               if (new_score >= MaxScoreC) begin
                  // Final win: round_reset stays high with the match frozen.
                  state_d     = StOver;
                  game_over_d = 1'b1;
                  winner_d    = left_win ? 2'b10 : 2'b01;
               end else begin
                  state_d = StHold;
                  hold_d  = HoldInitC;
               end
            end
         end
         StHold: begin
            // Counter loaded with HOLD_CYCLES-1, so round_reset spans exactly HOLD_CYCLES cycles.
            if (hold_q == 8'd0) begin
               state_d       = StPlay;
               round_reset_d = 1'b0;
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end
         StOver: begin
            state_d = StOver;
         end
         default: begin
            state_d       = StPlay;
            round_reset_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StPlay;
         score_l_q     <= 4'd0;
         score_r_q     <= 4'd0;
         hold_q        <= 8'd0;
         round_reset_q <= 1'b0;
         game_over_q   <= 1'b0;
         winner_q      <= 2'b00;
      end else begin
         state_q       <= state_d;
         score_l_q     <= score_l_d;
         score_r_q     <= score_r_d;
         hold_q        <= hold_d;
         round_reset_q <= round_reset_d;
         game_over_q   <= game_over_d;
         winner_q      <= winner_d;
      end
   end

   assign HEX1        = seg7(score_l_q);
   assign HEX0        = seg7(score_r_q);
   assign round_reset = round_reset_q;
   assign game_over   = game_over_q;
   assign winner      = winner_q;

endmodule

// File: tb/tb_tug_score_keeper.sv
// Table-driven bench for tug_score_keeper with an expected-value queue: each applied vector
// pushes its expected outputs, which are popped and compared one cycle later.
module tb_tug_score_keeper;

   localparam logic [6:0] SEG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

   logic       clk = 1'b0;
   logic       rst_n, l_in, r_in, led_l, led_r;
   logic [6:0] hex1, hex0;
   logic       rr, go;
   logic [1:0] win;

   typedef struct {
      logic       rst_n;
      logic       l;
      logic       r;
      logic       ll;
      logic       lr;
      logic [6:0] hex1;
      logic [6:0] hex0;
      logic       rr;
      logic       go;
      logic [1:0] win;
   } vec_t;

   typedef struct {
      logic [6:0] hex1;
      logic [6:0] hex0;
      logic       rr;
      logic       go;
      logic [1:0] win;
      string      name;
   } exp_t;

   vec_t tbl[$];
   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   tug_score_keeper #(
      .MAX_SCORE  (7),
      .HOLD_CYCLES(4)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .L          (l_in),
      .R          (r_in),
      .led_left   (led_l),
      .led_right  (led_r),
      .HEX1       (hex1),
      .HEX0       (hex0),
      .round_reset(rr),
      .game_over  (go),
      .winner     (win)
   );

   always #5 clk = ~clk;

   task automatic add(input logic a_rst, a_l, a_r, a_ll, a_lr, input logic [6:0] e_h1, e_h0,
                      input logic e_rr, e_go, input logic [1:0] e_win);
      vec_t v;
      v.rst_n = a_rst; v.l = a_l; v.r = a_r; v.ll = a_ll; v.lr = a_lr;
      v.hex1 = e_h1; v.hex0 = e_h0; v.rr = e_rr; v.go = e_go; v.win = e_win;
      tbl.push_back(v);
   endtask

   task automatic check();
      exp_t e;
      if (sb_q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: no expected entry for DUT output");
      end else begin
         e = sb_q.pop_front();
         vectors++;
         if ({hex1, hex0, rr, go, win} !== {e.hex1, e.hex0, e.rr, e.go, e.win}) begin
            miscompares++;
            $display("FAIL %s: got HEX1=%b HEX0=%b rr=%b go=%b win=%b, want HEX1=%b HEX0=%b rr=%b go=%b win=%b",
                     e.name, hex1, hex0, rr, go, win, e.hex1, e.hex0, e.rr, e.go, e.win);
         end
      end
   endtask

   // Drive one cycle of stimulus, queue its expected outputs, sample 1 time unit after the edge.
   task automatic apply(input logic a_rst, a_l, a_r, a_ll, a_lr, input logic [6:0] e_h1, e_h0,
                        input logic e_rr, e_go, input logic [1:0] e_win, input string name);
      exp_t e;
      rst_n = a_rst; l_in = a_l; r_in = a_r; led_l = a_ll; led_r = a_lr;
      e.hex1 = e_h1; e.hex0 = e_h0; e.rr = e_rr; e.go = e_go; e.win = e_win; e.name = name;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check();
   endtask

   initial begin
      logic [6:0] z, s1, s2;
      z  = SEG[0];
      s1 = SEG[1];
      s2 = SEG[2];
      rst_n = 1'b1; l_in = 1'b0; r_in = 1'b0; led_l = 1'b0; led_r = 1'b0;

      // Reset then idle.
      add(0, 0, 0, 0, 0, z, z, 0, 0, 2'b00);
      for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, z, z, 0, 0, 2'b00);
      // Left round win, then exactly four cycles of round_reset.
      add(1, 1, 0, 1, 0, s1, z, 1, 0, 2'b00);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, s1, z, 1, 0, 2'b00);
      add(1, 0, 0, 0, 0, s1, z, 0, 0, 2'b00);
      // Tie with both edge lights lit.
      add(1, 1, 1, 1, 1, s1, z, 0, 0, 2'b00);
      // Right win, then presses during HOLD are ignored.
      add(1, 0, 1, 0, 1, s1, s1, 1, 0, 2'b00);
      add(1, 0, 1, 0, 1, s1, s1, 1, 0, 2'b00);
      add(1, 1, 0, 1, 0, s1, s1, 1, 0, 2'b00);
      add(1, 0, 0, 0, 0, s1, s1, 1, 0, 2'b00);
      add(1, 0, 0, 0, 0, s1, s1, 0, 0, 2'b00);
      // Presses without the matching edge light lit.
      for (int i = 0; i < 5; i++) begin
         add(1, 1, 0, 0, 1, s1, s1, 0, 0, 2'b00);
         add(1, 0, 0, 0, 0, s1, s1, 0, 0, 2'b00);
      end
      add(1, 0, 1, 1, 0, s1, s1, 0, 0, 2'b00);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].rst_n, tbl[i].l, tbl[i].r, tbl[i].ll, tbl[i].lr, tbl[i].hex1, tbl[i].hex0,
               tbl[i].rr, tbl[i].go, tbl[i].win, $sformatf("vec%0d", i));
      end

      // Reset during the second HOLD cycle.
      apply(1, 1, 0, 1, 0, s2, s1, 1, 0, 2'b00, "hold_win");
      apply(1, 0, 0, 0, 0, s2, s1, 1, 0, 2'b00, "hold_cycle2");
      apply(0, 0, 0, 0, 0, z, z, 0, 0, 2'b00, "reset_mid_hold");
      apply(1, 0, 0, 0, 0, z, z, 0, 0, 2'b00, "after_reset_hold");

      // Seven right wins end the match.
      for (int k = 1; k <= 7; k++) begin
         apply(1, 0, 1, 0, 1, z, SEG[k], 1, (k == 7), (k == 7) ? 2'b01 : 2'b00,
               $sformatf("right_win%0d", k));
         if (k < 7) begin
            for (int j = 0; j < 3; j++) apply(1, 0, 0, 0, 0, z, SEG[k], 1, 0, 2'b00, "hold_hi");
            apply(1, 0, 0, 0, 0, z, SEG[k], 0, 0, 2'b00, "hold_end");
         end
      end
      for (int i = 0; i < 20; i++) begin
         apply(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), z, SEG[7], 1, 1, 2'b01, "over_frozen");
      end
      apply(0, 0, 0, 0, 0, z, z, 0, 0, 2'b00, "reset_in_over");
      apply(1, 0, 0, 0, 0, z, z, 0, 0, 2'b00, "after_reset_over");
      apply(1, 1, 0, 1, 0, s1, z, 1, 0, 2'b00, "win_after_over");

      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: %0d entries left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
